// File: rtl/e1_buf_wb_arb.sv
// e1_buf_wb_arb: shares the single-port E1 buffer SRAM between two classic
// single-beat wishbone masters.
//   m0 (E1 buffer interface) has priority. m1 (host / USB-DMA) is served after
//   at most HOST_MAX_WAIT consecutive m0 grants while it is requesting.
//   Transfer sequence: IDLE -> ACC -> ACK (ack at t+2, one transfer per 3 cycles).
//
// Optional build macro E1_BUF_ARB_RDATA_REG_EN:
//   Adds an RDW state (IDLE -> ACC -> RDW -> ACK). SRAM read data is registered
//   in RDW and returned from that register during ACK (ack at t+3, 4 cycles
//   per transfer). Without it, read data passes straight from mem_rdata.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m0_* / m1_*         wishbone masters: addr, wdata, wmsk (1 = lane kept),
//                       we, cyc in; rdata, ack out
//   mem_addr/wdata/wmsk/we  SRAM request (registered)
//   mem_rdata           SRAM read data, valid one cycle after the address
module e1_buf_wb_arb #(
    parameter int unsigned AW            = 14,
    parameter int unsigned DW            = 32,
    parameter int unsigned MW            = DW / 8,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [MW-1:0] m0_wmsk,
    input  logic          m0_we,
    input  logic          m0_cyc,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,

    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [MW-1:0] m1_wmsk,
    input  logic          m1_we,
    input  logic          m1_cyc,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_wmsk,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RDW  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } gnt_t;

    state_t          r_state;
    gnt_t            r_gnt;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [MW-1:0]   r_mem_wmsk;
    logic            r_mem_we;
    logic            r_m0_ack;
    logic            r_m1_ack;
`ifdef E1_BUF_ARB_RDATA_REG_EN
    logic [DW-1:0]   r_rdata;
`endif

    // m1 wins when it is the only requester, or when m0 has used up its
    // allowance of consecutive grants while m1 was waiting.
    logic w_cnt_at_max;
    logic w_pick_m1;

    assign w_cnt_at_max = (r_cnt == CW'(HOST_MAX_WAIT));
    assign w_pick_m1    = m1_cyc && (!m0_cyc || w_cnt_at_max);

    // Arbitration FSM, SRAM request registers and ack generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= GNT_NONE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmsk  <= '1;
            r_mem_we    <= 1'b0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
`ifdef E1_BUF_ARB_RDATA_REG_EN
            r_rdata     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!m1_cyc) begin
                        r_cnt <= '0;
                    end
                    if (m0_cyc || m1_cyc) begin
                        if (w_pick_m1) begin
                            r_gnt       <= GNT_M1;
                            r_mem_addr  <= m1_addr;
                            r_mem_wdata <= m1_wdata;
                            r_mem_wmsk  <= m1_wmsk;
                            r_mem_we    <= m1_we;
                            r_cnt       <= '0;
                        end else begin
                            r_gnt       <= GNT_M0;
                            r_mem_addr  <= m0_addr;
                            r_mem_wdata <= m0_wdata;
                            r_mem_wmsk  <= m0_wmsk;
                            r_mem_we    <= m0_we;
                            // Count m0 grants taken while m1 waits; saturate.
                            if (m1_cyc && !w_cnt_at_max) begin
                                r_cnt <= CW'(r_cnt + CW'(1));
                            end
                        end
                        r_state <= ST_ACC;
                    end
                end

                ST_ACC: begin
                    // Write strobe lives only in ACC; address is held onward.
                    r_mem_we   <= 1'b0;
                    r_mem_wmsk <= '1;
`ifdef E1_BUF_ARB_RDATA_REG_EN
                    r_state    <= ST_RDW;
`else
                    r_m0_ack   <= (r_gnt == GNT_M0);
                    r_m1_ack   <= (r_gnt == GNT_M1);
                    r_state    <= ST_ACK;
`endif
                end

`ifdef E1_BUF_ARB_RDATA_REG_EN
                ST_RDW: begin
                    r_rdata  <= mem_rdata;
                    r_m0_ack <= (r_gnt == GNT_M0);
                    r_m1_ack <= (r_gnt == GNT_M1);
                    r_state  <= ST_ACK;
                end
`endif

                ST_ACK: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_gnt    <= GNT_NONE;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_gnt    <= GNT_NONE;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmsk  = r_mem_wmsk;
    assign mem_we    = r_mem_we;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;

    // Both masters see the same read data; it is only meaningful with ack.
`ifdef E1_BUF_ARB_RDATA_REG_EN
    assign m0_rdata = r_rdata;
    assign m1_rdata = r_rdata;
`else
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;
`endif

endmodule
